// File: rtl/dmem_pkg.sv
// Shared constants and types for the data memory unit.
// Holds the MMIO map and the region-select encoding.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h0000_1000;

    localparam logic [3:0] GPIO_OUT  = 4'h0;
    localparam logic [3:0] GPIO_IN   = 4'h4;
    localparam logic [3:0] CYCLE_CNT = 4'h8;
    localparam logic [3:0] STORE_CNT = 4'hC;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_MMIO,
        SEL_NONE
    } sel_e;

endpackage

// File: rtl/data_memory_unit_sync.sv
// Two-flop synchronizer for asynchronous inputs.
// Output lags the input by two rising edges.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            o_q    <= '0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/data_memory_unit.sv
// Word-addressed data RAM plus a small MMIO block
// (GPIO out/in, cycle counter, store counter).
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] ram_address,
    input  logic [WIDTH-1:0] ram_w_data,
    input  logic             read_write_ram_en,
    output logic [WIDTH-1:0] ram_r_data,
    input  logic [7:0]       gpio_in,
    output logic [7:0]       gpio_out
);

    localparam int IDXW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [31:0]      r_cycle_cnt;
    logic [31:0]      r_store_cnt;
    logic [7:0]       w_gpio_sync;

    sel_e             w_sel;
    logic [3:0]       w_off;
    logic [IDXW-1:0]  w_idx;
    logic             w_ram_we;
    logic             w_mmio_we;
    logic             w_unused;

    assign w_unused = ^ram_address[1:0];

    sync_2ff #(
        .WIDTH(8)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .i_d  (gpio_in),
        .o_q  (w_gpio_sync)
    );

    always_comb begin
        w_sel      = SEL_NONE;
        w_off      = {ram_address[3:2], 2'b00};
        w_idx      = ram_address[IDXW+1:2];
        ram_r_data = '0;
        if ((ram_address >> (IDXW + 2)) == '0) begin
            w_sel      = SEL_RAM;
            ram_r_data = r_mem[w_idx];
        end else if ({ram_address[WIDTH-1:4], 4'h0} == WIDTH'(MMIO_BASE)) begin
            w_sel = SEL_MMIO;
            case (w_off)
                GPIO_OUT:  ram_r_data = WIDTH'(gpio_out);
                GPIO_IN:   ram_r_data = WIDTH'(w_gpio_sync);
                CYCLE_CNT: ram_r_data = WIDTH'(r_cycle_cnt);
                default:   ram_r_data = WIDTH'(r_store_cnt);
            endcase
        end
    end

    // Writes are gated by reset so a store presented during reset is dropped.
    assign w_ram_we  = read_write_ram_en && !reset && (w_sel == SEL_RAM);
    assign w_mmio_we = read_write_ram_en && !reset && (w_sel == SEL_MMIO);

    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_mem[w_idx] <= ram_w_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gpio_out <= '0;
        end else if (w_mmio_we && (w_off == GPIO_OUT)) begin
            gpio_out <= ram_w_data[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (w_mmio_we && (w_off == CYCLE_CNT)) begin
            r_cycle_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_store_cnt <= '0;
        end else if (w_mmio_we && (w_off == STORE_CNT)) begin
            r_store_cnt <= '0;
        end else if (w_ram_we) begin
            r_store_cnt <= r_store_cnt + 32'd1;
        end
    end

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 Parameter WIDTH, default 32, data/address width.
REQ-002 Parameter DEPTH, default 256, RAM words.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; all resettable state clears immediately on assertion.
REQ-005 ram_address  input  WIDTH  byte address from the core's EX/MEM stage.
REQ-006 ram_w_data  input  WIDTH  store data.
REQ-007 read_write_ram_en  input  1  1 = write this cycle, 0 = read.
REQ-008 ram_r_data  output  WIDTH  combinational read data, valid the same cycle as ram_address.
REQ-009 gpio_in  input  8  asynchronous external inputs.
REQ-010 gpio_out  output  8  registered output port.

Function
REQ-011 Decode: RAM region = 0x0000_0000 to (DEPTH*4 - 1); MMIO region = 0x0000_1000 to 0x0000_100F; all other addresses unmapped.
REQ-012 Word index = ram_address[9:2] for the RAM; ram_address[1:0] ignored everywhere (word accesses only).
REQ-013 RAM read: ram_r_data = array[index] combinationally, no added latency.
REQ-014 RAM write: when read_write_ram_en=1 and the address is in the RAM region, array[index] <= ram_w_data at the next rising edge.
REQ-015 Read-during-write to the same word: ram_r_data shows the old value during the write cycle and the new value from the next cycle.
REQ-016 MMIO 0x1000 GPIO_OUT: read returns {24'b0, gpio_out}; write loads gpio_out <= ram_w_data[7:0].
REQ-017 MMIO 0x1004 GPIO_IN: read returns {24'b0, gpio_sync}; gpio_sync is gpio_in through a 2-flop synchronizer (2-cycle latency); writes are ignored.
REQ-018 MMIO 0x1008 CYCLE_CNT: 32-bit counter incrementing every cycle out of reset, wrapping 0xFFFF_FFFF -> 0; any write clears it to 0, and a clear takes priority over that cycle's increment.
REQ-019 MMIO 0x100C STORE_CNT: 32-bit counter incrementing once per accepted RAM-region write, wrapping to 0; any write to 0x100C clears it to 0.
REQ-020 Unmapped address: read returns 0x0000_0000; write has no effect on any state.
REQ-021 MMIO reads are combinational and return the register value held before the current edge.

Reset
REQ-022 On reset: gpio_out=0, both synchronizer stages=0, CYCLE_CNT=0, STORE_CNT=0.
REQ-023 RAM array contents are not reset and are undefined until written.
REQ-024 After reset deassertion, CYCLE_CNT reads 0 in the first cycle and increments from the first rising edge with reset low.
REQ-025 A write presented while reset is high is discarded.

Structure
REQ-026 A shared package dmem_pkg holds constants MMIO_BASE=0x1000, offsets GPIO_OUT=0x0, GPIO_IN=0x4, CYCLE_CNT=0x8, STORE_CNT=0xC, and the region-select enum {SEL_RAM, SEL_MMIO, SEL_NONE}.
REQ-027 One sub-module, sync_2ff, with parameter WIDTH=8 and the same clock/reset ports, implements the gpio_in synchronizer.
REQ-028 The address decode and the read-data mux are a single combinational process; the RAM, registers and counters are separate clocked processes.

Verification
REQ-029 Write 0xDEADBEEF to 0x10, then read 0x10 -> 0xDEADBEEF; a read of 0x13 returns the same word.
REQ-030 Write 0x5 to 0x20 while reading 0x20 in the same cycle -> old value during that cycle, 0x5 the following cycle; STORE_CNT increments by 1.
REQ-031 Write 0xA5 to 0x1000 -> gpio_out=0xA5 after the edge; drive gpio_in=0x3C -> reads of 0x1004 return 0x3C from the 2nd edge onward, not before.
REQ-032 Release reset and run 10 cycles -> CYCLE_CNT reads 10; write 0x1008 -> reads 0 in the next cycle, then 1.
REQ-033 Write to 0x2000 and 0x1004 -> no state change, STORE_CNT unchanged; a read of 0x2000 returns 0.
REQ-034 Assert reset mid-run after gpio_out=0xFF and STORE_CNT=3 -> both read 0 immediately (asynchronous), and a previously written RAM word is not checked.
